// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic line_sync
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta      <= 1'b1;
      line_sync <= 1'b1;
    end else begin
      meta      <= line;
      line_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART 8N1 receiver with majority sampling, glitch rejection, framing/break/overrun flags and a
// valid/ready output register. Optional parity bit when UART_PARITY_EN is defined.
//
// state     | meaning
// IDLE      | line high, waiting for a start edge
// START     | confirming the start bit at mid-bit, rejecting glitches
// DATA      | shifting in 8 data bits, LSB first
// PARITY    | sampling the parity bit (UART_PARITY_EN only)
// STOP      | half stop bit: deliver the byte or flag a framing error
// WAIT_IDLE | after a framing error, hold until the line returns high
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_serial,
  input  logic       i_rx_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic       o_break,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] SMP_C    = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  rx_state_t state, state_nx;

  logic                      line_s;
  logic [CW-1:0]             cnt, cnt_nx;
  logic [2:0]                bit_idx, bit_idx_nx;
  logic [UART_DATA_BITS-1:0] shift, shift_nx;
  logic                      s0, s0_nx, s1, s1_nx;
  logic                      maj, mid, bit_end;
  logic                      deliver_q, deliver_nx;
  logic                      ferr_nx, brk_nx;
  logic                      par_bad;

  uart_rx_sync u_sync (
    .clock    (i_clock),
    .reset    (i_reset),
    .line     (i_rx_serial),
    .line_sync(line_s)
  );

  assign maj       = majority3(s0, s1, line_s);
  assign mid       = (cnt == SMP_C);
  assign bit_end   = (cnt == CNT_LAST);
  assign o_rx_busy = (state != IDLE);

`ifdef UART_PARITY_EN
  logic perr_nx, par_bad_nx;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      par_bad      <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      par_bad      <= par_bad_nx;
      o_parity_err <= perr_nx;
    end
  end
`else
  assign par_bad = 1'b0;
  // PARITY_ODD has no effect on the 8N1 build
  assign o_parity_err = 1'b0 & PARITY_ODD;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = bit_end ? '0 : cnt + CW'(1);
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    s0_nx      = (cnt == SMP_A) ? line_s : s0;
    s1_nx      = (cnt == SMP_B) ? line_s : s1;
    deliver_nx = 1'b0;
    ferr_nx    = 1'b0;
    brk_nx     = 1'b0;
`ifdef UART_PARITY_EN
    perr_nx    = 1'b0;
    par_bad_nx = par_bad;
`endif
    case (state)
      IDLE: begin
        cnt_nx     = '0;
        bit_idx_nx = '0;
`ifdef UART_PARITY_EN
        par_bad_nx = 1'b0;
`endif
        if (!line_s) state_nx = START;
      end
      START: begin
        if (mid && maj)   state_nx = IDLE;
        else if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (mid) shift_nx = {maj, shift[UART_DATA_BITS-1:1]};
        if (bit_end) begin
          bit_idx_nx = bit_idx + 3'd1;
`ifdef UART_PARITY_EN
          if (bit_idx == BIT_LAST) state_nx = PARITY;
`else
          if (bit_idx == BIT_LAST) state_nx = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        // even parity expects the bit to equal the XOR of the data bits
        if (mid && (maj != ((^shift) ^ PARITY_ODD))) begin
          perr_nx    = 1'b1;
          par_bad_nx = 1'b1;
        end
        if (bit_end) state_nx = STOP;
      end
`endif
      STOP: begin
        if (mid) begin
          if (maj) begin
            deliver_nx = !par_bad;
            state_nx   = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            brk_nx   = (shift == '0);
            state_nx = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (line_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      deliver_q   <= 1'b0;
      o_frame_err <= 1'b0;
      o_break     <= 1'b0;
      o_overrun   <= 1'b0;
      o_rx_valid  <= 1'b0;
      o_rx_byte   <= '0;
    end else begin
      cnt         <= cnt_nx;
      bit_idx     <= bit_idx_nx;
      shift       <= shift_nx;
      s0          <= s0_nx;
      s1          <= s1_nx;
      deliver_q   <= deliver_nx;
      o_frame_err <= ferr_nx;
      o_break     <= brk_nx;
      o_overrun   <= 1'b0;
      // shift is untouched in IDLE, so it still holds the byte one cycle after the stop decision
      if (deliver_q) begin
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_byte  <= shift;
          o_rx_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

endmodule
